apb_toggle_arbiter: RTL and testbench
=====================================

# apb_toggle_arbiter

Round-robin arbiter in the b_pclk domain that shares one low-frequency APB master port among NUM_REQ requesters. Each requester lives in its own asynchronous clock domain and uses a toggle request/acknowledge pair. The block synchronizes each request, arbitrates, runs one APB transfer at a time, and returns read data, error status and an acknowledge toggle to the granted requester. It sits between the per-domain request logic and the slow APB peripheral bus.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, legal range 1..8
- ADDR_WD, 32: APB address width
- DATA_WD, 32: APB data width
- STRB_WD, 4: APB strobe width
- PROT_WD, 3: APB prot width
- TIMEOUT, 256: maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
- b_pclk  in  1  APB clock
- b_prst_n  in  1  reset, asynchronous, active-low
- req_tgl  in  NUM_REQ  per-requester request toggle (asynchronous)
- req_write  in  NUM_REQ  per-requester write flag
- req_addr  in  NUM_REQ*ADDR_WD  packed addresses; requester i occupies slice i
- req_wdata  in  NUM_REQ*DATA_WD  packed write data
- req_prot  in  NUM_REQ*PROT_WD  packed prot
- req_strb  in  NUM_REQ*STRB_WD  packed strobes
- ack_tgl  out  NUM_REQ  per-requester completion toggle
- rsp_rdata  out  NUM_REQ*DATA_WD  per-requester held read data
- rsp_err  out  NUM_REQ  per-requester error status for the last completed transfer
- busy  out  1  high while a transfer is in SETUP or ACCESS
- b_psel, b_penable, b_pwrite  out  1 each  APB control
- b_paddr  out  ADDR_WD  APB address
- b_pwdata  out  DATA_WD  APB write data
- b_pprot  out  PROT_WD  APB prot
- b_pstrb  out  STRB_WD  APB strobes
- b_prdata  in  DATA_WD  APB read data
- b_pready  in  1  APB ready
- b_pslverr  in  1  APB slave error

## Operation
- Requester protocol:
  - The requester sets its payload, then toggles req_tgl[i].
  - The payload is held stable until ack_tgl[i] toggles.
  - At most one outstanding request per requester.
- Request synchronization and pending flags:
  - Each req_tgl[i] passes through 2 sync flops plus 1 edge flop.
  - edge[i] = sync2 XOR edge flop.
  - edge[i] sets pending[i].
  - An edge while pending[i] is already 1 is ignored.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: if any pending bit is set, grant g = the first pending index searching upward from rr_ptr with wrap-around. Register the slice-g payload onto the b_p* outputs. Go to SETUP.
  - SETUP: b_psel=1, b_penable=0. Go to ACCESS unconditionally.
  - ACCESS: b_psel=1, b_penable=1. A 16-bit-safe counter increments each cycle b_pready=0.
- Completion happens on b_pready=1, or when the counter reaches TIMEOUT with TIMEOUT≠0. On completion:
  - Read transfer with pready: rsp_rdata slice g ← b_prdata.
  - Read transfer with timeout: rsp_rdata slice g ← 0.
  - Write transfer: rsp_rdata is unchanged.
  - rsp_err[g] ← b_pslverr on pready, or 1 on timeout.
  - ack_tgl[g] inverts, pending[g] clears, rr_ptr ← (g+1) mod NUM_REQ, counter clears, go to IDLE.
- Same-cycle events: pending set for index j and pending clear for index g both take effect. If j==g in the same cycle (a protocol violation), the clear wins.
- b_paddr, b_pwdata, b_pprot, b_pstrb and b_pwrite hold their last values while in IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; rr_ptr=0; pending=0; all sync flops 0.
- Reset mid-transfer: b_psel and b_penable drop asynchronously and the transfer is discarded. No ack is issued.
- Request latency: req_tgl toggles before b_pclk edge k → pending set at edge k+2 → SETUP (psel=1) after edge k+3.
- A zero-wait-state transfer occupies 2 cycles (SETUP, ACCESS). ack_tgl and rsp_* update on the pready edge.
- Back-to-back transfers always have exactly 1 IDLE cycle (psel=0) between them.
- A timeout completes at the end of the ACCESS cycle in which the counter equals TIMEOUT, i.e. TIMEOUT+1 ACCESS cycles.
- busy is a registered output, equal to (state≠IDLE).

## Test plan
- Single read, req 0, addr 0x10, pready on first ACCESS cycle, prdata 0xDEADBEEF → psel high 2 cycles, penable 1 cycle, rsp_rdata[0]=0xDEADBEEF, rsp_err[0]=0, ack_tgl[0] 0→1.
- Write from req 1, 3 wait states, pslverr=1 → psel high 5 cycles, rsp_rdata[1] unchanged, rsp_err[1]=1, ack_tgl[1] toggles.
- Requests 0 and 1 toggle on the same cycle, NUM_REQ=2 → grant 0 then 1, 1 idle cycle between transfers. Repeat both → grant order alternates (rr_ptr wraps).
- TIMEOUT=4, read with pready held 0 → psel drops after 5 ACCESS cycles, rsp_rdata=0, rsp_err=1, ack toggles.
- Assert b_prst_n low during ACCESS → psel, penable, busy and ack_tgl go to 0 immediately. After release, a new request completes normally.
- Requester toggles req_tgl twice without waiting for ack → only 1 transfer and 1 ack toggle.

Source files
------------

// File: rtl/apb_toggle_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ toggle-handshake requesters.
// Each request toggle is synchronized into b_pclk, arbitrated, and answered with an ack toggle.
module apb_toggle_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_WD = 32,
   parameter int unsigned DATA_WD = 32,
   parameter int unsigned STRB_WD = 4,
   parameter int unsigned PROT_WD = 3,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                         b_pclk,
   input  logic                         b_prst_n,
   input  logic [NUM_REQ-1:0]           req_tgl,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [NUM_REQ*ADDR_WD-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WD-1:0]   req_wdata,
   input  logic [NUM_REQ*PROT_WD-1:0]   req_prot,
   input  logic [NUM_REQ*STRB_WD-1:0]   req_strb,
   output logic [NUM_REQ-1:0]           ack_tgl,
   output logic [NUM_REQ*DATA_WD-1:0]   rsp_rdata,
   output logic [NUM_REQ-1:0]           rsp_err,
   output logic                         busy,
   output logic                         b_psel,
   output logic                         b_penable,
   output logic                         b_pwrite,
   output logic [ADDR_WD-1:0]           b_paddr,
   output logic [DATA_WD-1:0]           b_pwdata,
   output logic [PROT_WD-1:0]           b_pprot,
   output logic [STRB_WD-1:0]           b_pstrb,
   input  logic [DATA_WD-1:0]           b_prdata,
   input  logic                         b_pready,
   input  logic                         b_pslverr
);

   localparam int unsigned PTR_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_WD = 16;
   localparam bit          TO_EN  = (TIMEOUT != 0);
   localparam logic [CNT_WD-1:0] TO_LIM = CNT_WD'(TIMEOUT);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [NUM_REQ-1:0]         sync1_q;
   logic [NUM_REQ-1:0]         sync2_q;
   logic [NUM_REQ-1:0]         edge_q;
   logic [NUM_REQ-1:0]         edge_c;

   logic [1:0]                 state_q,   state_nxt;
   logic [NUM_REQ-1:0]         pending_q, pending_nxt;
   logic [PTR_WD-1:0]          rr_q,      rr_nxt;
   logic [PTR_WD-1:0]          grant_q,   grant_nxt;
   logic [CNT_WD-1:0]          cnt_q,     cnt_nxt;

   logic                       psel_nxt;
   logic                       penable_nxt;
   logic                       pwrite_nxt;
   logic [ADDR_WD-1:0]         paddr_nxt;
   logic [DATA_WD-1:0]         pwdata_nxt;
   logic [PROT_WD-1:0]         pprot_nxt;
   logic [STRB_WD-1:0]         pstrb_nxt;
   logic [NUM_REQ-1:0]         ack_nxt;
   logic [NUM_REQ*DATA_WD-1:0] rdata_nxt;
   logic [NUM_REQ-1:0]         err_nxt;
   logic                       busy_nxt;

   logic                       found;
   logic [PTR_WD-1:0]          pick;
   int unsigned                idx;
   logic                       done;

   // Two-flop synchronizer plus an edge flop per request toggle
   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         edge_q  <= '0;
      end else begin
         sync1_q <= req_tgl;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign edge_c = sync2_q ^ edge_q;

   // State and all registered outputs
   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         rr_q      <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         b_psel    <= 1'b0;
         b_penable <= 1'b0;
         b_pwrite  <= 1'b0;
         b_paddr   <= '0;
         b_pwdata  <= '0;
         b_pprot   <= '0;
         b_pstrb   <= '0;
         ack_tgl   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         pending_q <= pending_nxt;
         rr_q      <= rr_nxt;
         grant_q   <= grant_nxt;
         cnt_q     <= cnt_nxt;
         b_psel    <= psel_nxt;
         b_penable <= penable_nxt;
         b_pwrite  <= pwrite_nxt;
         b_paddr   <= paddr_nxt;
         b_pwdata  <= pwdata_nxt;
         b_pprot   <= pprot_nxt;
         b_pstrb   <= pstrb_nxt;
         ack_tgl   <= ack_nxt;
         rsp_rdata <= rdata_nxt;
         rsp_err   <= err_nxt;
         busy      <= busy_nxt;
      end
   end

   // Rotating search for the first pending requester at or above rr_q
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && pending_q[PTR_WD'(idx)]) begin
            found = 1'b1;
            pick  = PTR_WD'(idx);
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state_q;
      pending_nxt = pending_q | edge_c;
      rr_nxt      = rr_q;
      grant_nxt   = grant_q;
      cnt_nxt     = cnt_q;
      psel_nxt    = b_psel;
      penable_nxt = b_penable;
      pwrite_nxt  = b_pwrite;
      paddr_nxt   = b_paddr;
      pwdata_nxt  = b_pwdata;
      pprot_nxt   = b_pprot;
      pstrb_nxt   = b_pstrb;
      ack_nxt     = ack_tgl;
      rdata_nxt   = rsp_rdata;
      err_nxt     = rsp_err;
      busy_nxt    = busy;
      done        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_nxt   = ST_SETUP;
               grant_nxt   = pick;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               busy_nxt    = 1'b1;
               pwrite_nxt  = req_write[pick];
               paddr_nxt   = req_addr[pick*ADDR_WD +: ADDR_WD];
               pwdata_nxt  = req_wdata[pick*DATA_WD +: DATA_WD];
               pprot_nxt   = req_prot[pick*PROT_WD +: PROT_WD];
               pstrb_nxt   = req_strb[pick*STRB_WD +: STRB_WD];
            end
         end
         ST_SETUP: begin
            state_nxt   = ST_ACCESS;
            penable_nxt = 1'b1;
            cnt_nxt     = '0;
         end
         ST_ACCESS: begin
            // pready takes precedence when it coincides with the timeout limit
            done = b_pready || (TO_EN && (cnt_q == TO_LIM));
            if (done) begin
               state_nxt   = ST_IDLE;
               psel_nxt    = 1'b0;
               penable_nxt = 1'b0;
               busy_nxt    = 1'b0;
               cnt_nxt     = '0;
               if (!b_pwrite) begin
                  rdata_nxt[grant_q*DATA_WD +: DATA_WD] = b_pready ? b_prdata : '0;
               end
               err_nxt[grant_q]     = b_pready ? b_pslverr : 1'b1;
               ack_nxt[grant_q]     = ~ack_tgl[grant_q];
               pending_nxt[grant_q] = 1'b0;
               rr_nxt = (grant_q == PTR_WD'(NUM_REQ - 1)) ? '0 : grant_q + PTR_WD'(1);
            end else begin
               cnt_nxt = cnt_q + CNT_WD'(1);
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            busy_nxt    = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_toggle_arbiter.sv
// Directed bench for apb_toggle_arbiter: vector table of single transfers plus
// hand sequences for arbitration order, double toggles and reset mid-transfer.
module tb_apb_toggle_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned PW = 3;

   logic               b_pclk;
   logic               b_prst_n;
   logic [NR-1:0]      req_tgl;
   logic [NR-1:0]      req_write;
   logic [NR*AW-1:0]   req_addr;
   logic [NR*DW-1:0]   req_wdata;
   logic [NR*PW-1:0]   req_prot;
   logic [NR*SW-1:0]   req_strb;
   logic [NR-1:0]      ack_tgl;
   logic [NR*DW-1:0]   rsp_rdata;
   logic [NR-1:0]      rsp_err;
   logic               busy;
   logic               b_psel;
   logic               b_penable;
   logic               b_pwrite;
   logic [AW-1:0]      b_paddr;
   logic [DW-1:0]      b_pwdata;
   logic [PW-1:0]      b_pprot;
   logic [SW-1:0]      b_pstrb;
   logic [DW-1:0]      b_prdata;
   logic               b_pready;
   logic               b_pslverr;

   apb_toggle_arbiter #(
      .NUM_REQ (NR), .ADDR_WD (AW), .DATA_WD (DW),
      .STRB_WD (SW), .PROT_WD (PW), .TIMEOUT (4)
   ) dut (
      .b_pclk    (b_pclk),    .b_prst_n  (b_prst_n),
      .req_tgl   (req_tgl),   .req_write (req_write),
      .req_addr  (req_addr),  .req_wdata (req_wdata),
      .req_prot  (req_prot),  .req_strb  (req_strb),
      .ack_tgl   (ack_tgl),   .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),   .busy      (busy),
      .b_psel    (b_psel),    .b_penable (b_penable),
      .b_pwrite  (b_pwrite),  .b_paddr   (b_paddr),
      .b_pwdata  (b_pwdata),  .b_pprot   (b_pprot),
      .b_pstrb   (b_pstrb),   .b_prdata  (b_prdata),
      .b_pready  (b_pready),  .b_pslverr (b_pslverr)
   );

   initial begin
      b_pclk = 1'b0;
      forever #5 b_pclk = ~b_pclk;
   end

   typedef struct {
      int          req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;      // ACCESS cycles before pready; 255 = never
      logic [31:0] prdata;
      logic        slverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_psel;
   } vec_t;

   vec_t        vecs[6];
   vec_t        vr;
   int          n_cmp;
   int          n_bad;
   logic [NR-1:0] exp_ack;
   logic [31:0] seen_addr[4];
   int          seen_gap[4];
   int          seen_n;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One transfer from a single requester, acting as the APB slave
   task automatic run_vec(input vec_t v);
      int cyc = 0, psel_n = 0, pen_n = 0, acc = 0, first = 0;
      bit busy_bad = 0;
      logic [31:0] c_addr = '0, c_wdata = '0;
      logic [2:0]  c_prot = '0;
      logic [3:0]  c_strb = '0;
      logic        c_wr = 1'b0;
      req_write[v.req]            = v.wr;
      req_addr[v.req*AW +: AW]    = v.addr;
      req_wdata[v.req*DW +: DW]   = v.wdata;
      req_prot[v.req*PW +: PW]    = 3'(v.req + 2);
      req_strb[v.req*SW +: SW]    = v.strb;
      req_tgl[v.req]              = ~req_tgl[v.req];
      exp_ack[v.req]              = ~exp_ack[v.req];
      while (ack_tgl[v.req] !== exp_ack[v.req] && cyc < 100) begin
         @(negedge b_pclk);
         cyc++;
         if (busy !== b_psel) busy_bad = 1;
         if (b_psel && !b_penable && first == 0) begin
            first = cyc; c_addr = b_paddr; c_wdata = b_pwdata;
            c_prot = b_pprot; c_strb = b_pstrb; c_wr = b_pwrite;
         end
         if (b_psel) psel_n++;
         if (b_psel && b_penable) begin
            pen_n++;
            b_pready  = (acc == v.waits);
            b_prdata  = v.prdata;
            b_pslverr = v.slverr;
            acc++;
         end else begin
            b_pready = 1'b0; b_pslverr = 1'b0; b_prdata = '0;
         end
      end
      chk("ack_tgl", 64'(ack_tgl), 64'(exp_ack));
      chk("latency", 64'(first), 64'(4));
      chk("psel_cycles", 64'(psel_n), 64'(v.exp_psel));
      chk("penable_cycles", 64'(pen_n), 64'(v.exp_psel - 1));
      chk("paddr", 64'(c_addr), 64'(v.addr));
      chk("pwrite", 64'(c_wr), 64'(v.wr));
      chk("pwdata", 64'(c_wdata), 64'(v.wdata));
      chk("pprot", 64'(c_prot), 64'(3'(v.req + 2)));
      chk("pstrb", 64'(c_strb), 64'(v.strb));
      chk("rsp_rdata", 64'(rsp_rdata[v.req*DW +: DW]), 64'(v.exp_rdata));
      chk("rsp_err", 64'(rsp_err[v.req]), 64'(v.exp_err));
      chk("busy_eq_psel", 64'(busy_bad), 64'(0));
      chk("idle_psel", 64'(b_psel), 64'(0));
      chk("idle_paddr_hold", 64'(b_paddr), 64'(v.addr));
   endtask

   // Zero-wait slave for up to n transfers; records SETUP address and idle gap before it
   task automatic serve(input int n, input int budget);
      int cyc = 0, idle = 0;
      seen_n = 0;
      while (seen_n < n && cyc < budget) begin
         @(negedge b_pclk);
         cyc++;
         b_pready = 1'b0;
         if (!b_psel) idle++;
         else if (!b_penable) begin
            if (seen_n < 4) begin
               seen_addr[seen_n] = b_paddr;
               seen_gap[seen_n]  = idle;
            end
            idle = 0;
         end else begin
            b_pready  = 1'b1;
            b_prdata  = 32'h1111_0000 + 32'(seen_n);
            b_pslverr = 1'b0;
            seen_n++;
         end
      end
      @(negedge b_pclk);
      b_pready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      n_cmp = 0; n_bad = 0; exp_ack = '0;
      b_prst_n = 1'b0; req_tgl = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      req_prot = '0; req_strb = '0; b_prdata = '0; b_pready = 1'b0; b_pslverr = 1'b0;

      vecs[0] = '{req:0, wr:1'b0, addr:32'h10, wdata:32'h0, strb:4'h0, waits:0,
                  prdata:32'hDEADBEEF, slverr:1'b0, exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_psel:2};
      vecs[1] = '{req:1, wr:1'b1, addr:32'h24, wdata:32'hA5A5_0001, strb:4'hF, waits:3,
                  prdata:32'h1234_5678, slverr:1'b1, exp_rdata:32'h0, exp_err:1'b1, exp_psel:5};
      vecs[2] = '{req:1, wr:1'b0, addr:32'h30, wdata:32'h0, strb:4'h0, waits:1,
                  prdata:32'hCAFEF00D, slverr:1'b0, exp_rdata:32'hCAFEF00D, exp_err:1'b0, exp_psel:3};
      vecs[3] = '{req:0, wr:1'b0, addr:32'h44, wdata:32'h0, strb:4'h0, waits:255,
                  prdata:32'hFFFF_FFFF, slverr:1'b0, exp_rdata:32'h0, exp_err:1'b1, exp_psel:6};
      vecs[4] = '{req:1, wr:1'b1, addr:32'h58, wdata:32'h0000_BEEF, strb:4'h3, waits:0,
                  prdata:32'h7777_7777, slverr:1'b0, exp_rdata:32'hCAFEF00D, exp_err:1'b0, exp_psel:2};
      vecs[5] = '{req:0, wr:1'b0, addr:32'h6C, wdata:32'h0, strb:4'h0, waits:4,
                  prdata:32'h0BADF00D, slverr:1'b0, exp_rdata:32'h0BADF00D, exp_err:1'b0, exp_psel:6};

      repeat (3) @(negedge b_pclk);
      chk("rst_psel", 64'(b_psel), 64'(0));
      chk("rst_penable", 64'(b_penable), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ack", 64'(ack_tgl), 64'(0));
      chk("rst_err", 64'(rsp_err), 64'(0));
      chk("rst_rdata", rsp_rdata, 64'(0));
      chk("rst_paddr", 64'(b_paddr), 64'(0));
      b_prst_n = 1'b1;
      @(negedge b_pclk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Last completion was requester 0, so rr points at 1: expect 1 then 0
      req_write = '0;
      req_addr[0*AW +: AW] = 32'h100;
      req_addr[1*AW +: AW] = 32'h104;
      req_tgl = ~req_tgl;
      exp_ack = ~exp_ack;
      serve(2, 40);
      chk("pairA_count", 64'(seen_n), 64'(2));
      chk("pairA_first", 64'(seen_addr[0]), 64'(32'h104));
      chk("pairA_second", 64'(seen_addr[1]), 64'(32'h100));
      chk("pairA_gap", 64'(seen_gap[1]), 64'(1));
      chk("pairA_ack", 64'(ack_tgl), 64'(exp_ack));
      chk("pairA_err", 64'(rsp_err), 64'(0));

      // Single request from 1 moves rr to 0
      req_addr[1*AW +: AW] = 32'h108;
      req_tgl[1] = ~req_tgl[1];
      exp_ack[1] = ~exp_ack[1];
      serve(1, 20);
      chk("single_addr", 64'(seen_addr[0]), 64'(32'h108));
      chk("single_rdata", 64'(rsp_rdata[1*DW +: DW]), 64'(32'h1111_0000));

      req_addr[1*AW +: AW] = 32'h104;
      req_tgl = ~req_tgl;
      exp_ack = ~exp_ack;
      serve(2, 40);
      chk("pairB_count", 64'(seen_n), 64'(2));
      chk("pairB_first", 64'(seen_addr[0]), 64'(32'h100));
      chk("pairB_second", 64'(seen_addr[1]), 64'(32'h104));
      chk("pairB_gap", 64'(seen_gap[1]), 64'(1));
      chk("pairB_ack", 64'(ack_tgl), 64'(exp_ack));

      // Two toggles without waiting for ack yield one transfer
      req_addr[0*AW +: AW] = 32'h200;
      req_tgl[0] = ~req_tgl[0];
      @(negedge b_pclk);
      req_tgl[0] = ~req_tgl[0];
      exp_ack[0] = ~exp_ack[0];
      serve(2, 30);
      chk("dbl_count", 64'(seen_n), 64'(1));
      chk("dbl_addr", 64'(seen_addr[0]), 64'(32'h200));
      chk("dbl_ack", 64'(ack_tgl), 64'(exp_ack));

      // Reset asserted in the middle of an ACCESS phase
      req_addr[1*AW +: AW] = 32'h300;
      req_tgl[1] = ~req_tgl[1];
      b_pready = 1'b0;
      cyc = 0;
      while (!(b_psel && b_penable) && cyc < 20) begin
         @(negedge b_pclk);
         cyc++;
      end
      chk("rst_mid_reached_access", 64'(b_psel && b_penable), 64'(1));
      @(negedge b_pclk);
      #2;
      b_prst_n = 1'b0;
      req_tgl = '0;
      #1;
      chk("rstmid_psel", 64'(b_psel), 64'(0));
      chk("rstmid_penable", 64'(b_penable), 64'(0));
      chk("rstmid_busy", 64'(busy), 64'(0));
      chk("rstmid_ack", 64'(ack_tgl), 64'(0));
      exp_ack = '0;
      repeat (2) @(negedge b_pclk);
      b_prst_n = 1'b1;
      @(negedge b_pclk);
      chk("post_rst_idle", 64'(b_psel), 64'(0));
      vr = '{req:0, wr:1'b0, addr:32'h40, wdata:32'h0, strb:4'h5, waits:0,
             prdata:32'h55AA55AA, slverr:1'b0, exp_rdata:32'h55AA55AA, exp_err:1'b0, exp_psel:2};
      run_vec(vr);
      chk("post_rst_req1_rdata", 64'(rsp_rdata[1*DW +: DW]), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
